// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: sequences loads/stores over a req/ack port,
// stalls the pipeline until completion and returns extended load data.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        access_fault,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        bus_err_q, bus_err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] daddr_q, daddr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdat_q, wdat_d;

  logic        access, legal_ld, legal_st, misaligned, fault, start;
  logic [3:0]  strb_fmt;
  logic [31:0] wdata_fmt;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;

  // Request decode and fault detection on the EX/MEM contents
  always_comb begin
    access     = (mem_read | mem_write) & ~flush;
    legal_ld   = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) |
                 (funct3 == 3'b100) | (funct3 == 3'b101);
    legal_st   = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010);
    misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    fault      = access & ((mem_read & ~legal_ld) | (mem_write & ~legal_st) |
                           misaligned | (mem_read & mem_write));
    start      = (state_q == IDLE) & access & ~fault;
  end

  assign stall        = start | (state_q == BUSY);
  assign access_fault = fault;

  always_comb begin
    strb_fmt  = 4'b1111;
    wdata_fmt = wdata;
    case (funct3[1:0])
      2'b00: begin
        strb_fmt  = 4'b0001 << addr[1:0];
        wdata_fmt = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb_fmt  = 4'b0011 << addr[1:0];
        wdata_fmt = {2{wdata[15:0]}};
      end
      default: begin
        strb_fmt  = 4'b1111;
        wdata_fmt = wdata;
      end
    endcase
  end

  always_comb begin
    byte_v = dmem_rdata[8*off_q +: 8];
    half_v = dmem_rdata[16*off_q[1] +: 16];
    case (f3_q)
      3'b000:  ext_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  ext_v = {24'd0, byte_v};
      3'b001:  ext_v = {{16{half_v[15]}}, half_v};
      3'b101:  ext_v = {16'd0, half_v};
      default: ext_v = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    f3_d         = f3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    req_d        = req_q;
    we_d         = we_q;
    daddr_d      = daddr_q;
    wstrb_d      = wstrb_q;
    wdat_d       = wdat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_load_d = mem_read;
          f3_d      = funct3;
          off_d     = addr[1:0];
          cnt_d     = 8'd0;
          req_d     = 1'b1;
          we_d      = mem_write;
          daddr_d   = {addr[31:2], 2'b00};
          wstrb_d   = mem_write ? strb_fmt : 4'b0000;
          wdat_d    = mem_write ? wdata_fmt : 32'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // Ack wins over a timeout landing in the same cycle
        if (dmem_ack) begin
          req_d        = 1'b0;
          load_valid_d = is_load_q;
          if (is_load_q) load_data_d = ext_v;
          state_d      = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d       = 1'b0;
          bus_err_d   = 1'b1;
          load_data_d = 32'd0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      is_load_q    <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      cnt_q        <= 8'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      daddr_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      wdat_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
      req_q        <= req_d;
      we_q         <= we_d;
      daddr_q      <= daddr_d;
      wstrb_q      <= wstrb_d;
      wdat_q       <= wdat_d;
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wstrb = wstrb_q;
  assign dmem_wdata = wdat_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a short timeout; bus and load results are
// checked against expectations queued when each access is issued.
module tb_dmem_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, flush, dmem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, dmem_rdata;
  logic        stall, access_fault, load_valid, bus_err, dmem_req, dmem_we;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wd;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] ld_q[$];

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .flush(flush),
    .stall(stall), .access_fault(access_fault), .load_data(load_data),
    .load_valid(load_valid), .bus_err(bus_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
  endtask

  // ack_cyc = 0 means no ack (expect timeout after T busy cycles)
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rdv,
                           input int ack_cyc, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wd, input logic [31:0] exp_ld);
    bus_exp_t be;
    int last, nst;
    logic err;
    err  = (ack_cyc == 0);
    last = err ? T : ack_cyc;
    bus_q.push_back('{a: {a[31:2], 2'b00}, we: wr, strb: exp_strb, wd: exp_wd});
    if (rd && !err) ld_q.push_back(exp_ld);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; flush = 1'b0;
    #1;
    nst = (stall === 1'b1) ? 1 : 0;
    chk({tag, ".fault"}, 32'(access_fault), 32'd0);
    chk({tag, ".req_c0"}, 32'(dmem_req), 32'd0);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      if (stall === 1'b1) nst++;
      chk({tag, ".req"}, 32'(dmem_req), 32'd1);
      if (c == 1) begin
        if (bus_q.size() == 0) begin
          chk({tag, ".bus_q_empty"}, 32'd1, 32'd0);
        end else begin
          be = bus_q.pop_front();
          chk({tag, ".addr"}, dmem_addr, be.a);
          chk({tag, ".we"}, 32'(dmem_we), 32'(be.we));
          chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(be.strb));
          if (be.we) chk({tag, ".wdata"}, dmem_wdata, be.wd);
        end
      end
      if (c == ack_cyc) begin
        dmem_ack = 1'b1; dmem_rdata = rdv;
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    clear_inputs();
    #1;
    chk({tag, ".stall_cycles"}, 32'(nst), 32'(last + 1));
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".req_done"}, 32'(dmem_req), 32'd0);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(err));
    chk({tag, ".load_valid"}, 32'(load_valid), 32'(rd && !err));
    if (err) chk({tag, ".ld_zero"}, load_data, 32'd0);
    if (load_valid === 1'b1) begin
      if (ld_q.size() == 0) chk({tag, ".ld_q_empty"}, 32'd1, 32'd0);
      else chk({tag, ".load_data"}, load_data, ld_q.pop_front());
    end
  endtask

  task automatic fault_case(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic fl, input logic exp_fault);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; flush = fl;
    #1;
    chk({tag, ".fault"}, 32'(access_fault), 32'(exp_fault));
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".req"}, 32'(dmem_req), 32'd0);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.load_valid", 32'(load_valid), 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    chk("rst.load_data", load_data, 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wstrb", 32'(dmem_wstrb), 32'd0);
    rst = 1'b0;

    do_access("lw", 1, 0, 3'b010, 32'h104, 32'd0, 32'hDEADBEEF, 1, 4'b0000, 32'd0, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("lw.valid_after", 32'(load_valid), 32'd0);
    chk("lw.data_hold", load_data, 32'hDEADBEEF);

    do_access("lb", 1, 0, 3'b000, 32'h203, 32'd0, 32'h80FF_0000, 1, 4'b0000, 32'd0, 32'hFFFFFF80);
    do_access("lbu", 1, 0, 3'b100, 32'h203, 32'd0, 32'h80FF_0000, 2, 4'b0000, 32'd0, 32'h00000080);
    do_access("lh", 1, 0, 3'b001, 32'h202, 32'd0, 32'h80FF_0000, 1, 4'b0000, 32'd0, 32'hFFFF80FF);
    do_access("lhu", 1, 0, 3'b101, 32'h200, 32'd0, 32'h1234_F00D, 1, 4'b0000, 32'd0, 32'h0000F00D);
    do_access("sb", 0, 1, 3'b000, 32'h302, 32'h000000A5, 32'd0, 1, 4'b0100, 32'hA5A5A5A5, 32'd0);
    do_access("sh", 0, 1, 3'b001, 32'h302, 32'h00001234, 32'd0, 3, 4'b1100, 32'h12341234, 32'd0);
    do_access("sw", 0, 1, 3'b010, 32'h308, 32'hCAFEF00D, 32'd0, 1, 4'b1111, 32'hCAFEF00D, 32'd0);

    fault_case("mis_lw", 1, 0, 3'b010, 32'h101, 0, 1);
    fault_case("mis_lh", 1, 0, 3'b001, 32'h103, 0, 1);
    fault_case("rdwr", 1, 1, 3'b010, 32'h100, 0, 1);
    fault_case("f3_011", 1, 0, 3'b011, 32'h100, 0, 1);
    fault_case("sbu_st", 0, 1, 3'b100, 32'h100, 0, 1);
    fault_case("flush", 1, 0, 3'b010, 32'h100, 1, 0);

    do_access("timeout", 1, 0, 3'b010, 32'h400, 32'd0, 32'd0, 0, 4'b0000, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("timeout.err_pulse", 32'(bus_err), 32'd0);
    do_access("ack_at_limit", 1, 0, 3'b010, 32'h404, 32'd0, 32'h0BADF00D, T, 4'b0000, 32'd0, 32'h0BADF00D);

    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
    @(posedge clk); #1;
    chk("idle_ack.req", 32'(dmem_req), 32'd0);
    chk("idle_ack.valid", 32'(load_valid), 32'd0);
    dmem_ack = 1'b0; dmem_rdata = 32'd0;

    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk); #1;
    chk("rst_busy.req_before", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    chk("rst_busy.req", 32'(dmem_req), 32'd0);
    chk("rst_busy.stall", 32'(stall), 32'd0);
    rst = 1'b0;
    do_access("lw_after_rst", 1, 0, 3'b010, 32'h600, 32'd0, 32'h13579BDF, 2, 4'b0000, 32'd0, 32'h13579BDF);

    chk("queues_drained", 32'(bus_q.size() + ld_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
